// File: rtl/mul_seq.sv
// mul_seq: multi-cycle RV32M multiply sequencer (MUL, MULH, MULHSU, MULHU).
// Radix-2 shift-add over a single time-shared 32-bit adder (add32). Signed
// operands are converted to magnitudes before iterating, and the 64-bit
// product is negated afterwards when the signs differ.
//
// Optional build macro: MUL_SEQ_ZERO_BYPASS_EN
//   When defined, a zero operand skips straight to DONE with a zero product.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present (sampled only while req_ready is high)
//   req_ready  high only while idle
//   op         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1, rs2   multiplicand / multiplier
//   resp_valid result available
//   resp_ready consumer accepts result
//   result     low product word for MUL, high word otherwise
//   busy       high whenever a request is in flight

// add32: 32-bit adder built from 4-bit groups with group generate/propagate
// lookahead between groups and a ripple inside each group.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_1,
    output logic [31:0] s,
    output logic        c31
);
    logic [31:0] gen_s;
    logic [31:0] prop_s;

    assign gen_s  = a & b;
    assign prop_s = a ^ b;

    // Per-group sum ripple plus group-level carry lookahead.
    always_comb begin : add_p
        logic grp_c_s;
        logic bit_c_s;
        logic grp_g_s;
        logic grp_p_s;
        s       = 32'd0;
        grp_c_s = c_1;
        bit_c_s = 1'b0;
        grp_g_s = 1'b0;
        grp_p_s = 1'b1;
        for (int g = 0; g < 8; g++) begin
            bit_c_s = grp_c_s;
            grp_g_s = 1'b0;
            grp_p_s = 1'b1;
            for (int k = 0; k < 4; k++) begin
                s[4*g+k] = prop_s[4*g+k] ^ bit_c_s;
                bit_c_s  = gen_s[4*g+k] | (prop_s[4*g+k] & bit_c_s);
                grp_g_s  = gen_s[4*g+k] | (prop_s[4*g+k] & grp_g_s);
                grp_p_s  = grp_p_s & prop_s[4*g+k];
            end
            grp_c_s = grp_g_s | (grp_p_s & grp_c_s);
        end
        c31 = grp_c_s;
    end
endmodule

module mul_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t         state_r, state_nx_s;
    logic [31:0]    m_r, m_nx_s;
    logic [63:0]    p_r, p_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic           neg_r, neg_nx_s;
    logic [1:0]     op_r, op_nx_s;
    logic           carry_r, carry_nx_s;
    logic           resp_valid_r;
    logic [31:0]    result_r;
    logic           busy_r;
    logic           req_ready_r;

    logic [31:0]    add_a_s, add_b_s, sum_s;
    logic           add_c_s, cout_s;
    logic           neg_a_in_s, neg_b_in_s;

    // Sign handling decided from the incoming op: rs1 signed for MULH/MULHSU,
    // rs2 signed for MULH only.
    assign neg_a_in_s = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[31];
    assign neg_b_in_s = (op == OP_MULH) && rs2[31];

    add32 u_add (
        .a   (add_a_s),
        .b   (add_b_s),
        .c_1 (add_c_s),
        .s   (sum_s),
        .c31 (cout_s)
    );

    // FSM next-state, datapath updates and adder operand steering.
    always_comb begin
        state_nx_s = state_r;
        m_nx_s     = m_r;
        p_nx_s     = p_r;
        cnt_nx_s   = cnt_r;
        neg_nx_s   = neg_r;
        op_nx_s    = op_r;
        carry_nx_s = carry_r;
        add_a_s    = 32'd0;
        add_b_s    = 32'd0;
        add_c_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    m_nx_s   = rs1;
                    p_nx_s   = {32'd0, rs2};
                    op_nx_s  = op;
                    neg_nx_s = neg_a_in_s ^ neg_b_in_s;
                    cnt_nx_s = {CNT_W{1'b0}};
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                    if ((rs1 == 32'd0) || (rs2 == 32'd0)) begin
                        p_nx_s     = 64'd0;
                        state_nx_s = DONE;
                    end else if (neg_a_in_s) begin
                        state_nx_s = NEG_A;
                    end else if (neg_b_in_s) begin
                        state_nx_s = NEG_B;
                    end else begin
                        state_nx_s = ITER;
                    end
`else
                    if (neg_a_in_s) begin
                        state_nx_s = NEG_A;
                    end else if (neg_b_in_s) begin
                        state_nx_s = NEG_B;
                    end else begin
                        state_nx_s = ITER;
                    end
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            NEG_A: begin
                add_a_s = ~m_r;
                add_c_s = 1'b1;
                m_nx_s  = sum_s;
                // P[31:0] still holds raw rs2, so its sign bit is still valid here.
                if ((op_r == OP_MULH) && p_r[31]) begin
                    state_nx_s = NEG_B;
                end else begin
                    state_nx_s = ITER;
                end
            end
            NEG_B: begin
                add_a_s      = ~p_r[31:0];
                add_c_s      = 1'b1;
                p_nx_s[31:0] = sum_s;
                state_nx_s   = ITER;
            end
            ITER: begin
                if (p_r[0]) begin
                    add_a_s = p_r[63:32];
                    add_b_s = m_r;
                    p_nx_s  = {cout_s, sum_s, p_r[31:1]};
                end else begin
                    p_nx_s  = {1'b0, p_r[63:1]};
                end
                cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == {CNT_W{1'b1}}) begin
                    state_nx_s = neg_r ? NEG_LO : DONE;
                end else begin
                    state_nx_s = ITER;
                end
            end
            NEG_LO: begin
                add_a_s      = ~p_r[31:0];
                add_c_s      = 1'b1;
                p_nx_s[31:0] = sum_s;
                carry_nx_s   = cout_s;
                state_nx_s   = NEG_HI;
            end
            NEG_HI: begin
                // Carry out of the low-word negation completes the 64-bit two's complement.
                add_a_s       = ~p_r[63:32];
                add_c_s       = carry_r;
                p_nx_s[63:32] = sum_s;
                state_nx_s    = DONE;
            end
            DONE: begin
                if (resp_valid_r && resp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            m_r     <= 32'd0;
            p_r     <= 64'd0;
            cnt_r   <= {CNT_W{1'b0}};
            neg_r   <= 1'b0;
            op_r    <= 2'b00;
            carry_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            m_r     <= m_nx_s;
            p_r     <= p_nx_s;
            cnt_r   <= cnt_nx_s;
            neg_r   <= neg_nx_s;
            op_r    <= op_nx_s;
            carry_r <= carry_nx_s;
        end
    end

    // Registered outputs; the response is presented one cycle after DONE is entered
    // and drops on the same edge that returns the FSM to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            result_r     <= 32'd0;
            busy_r       <= 1'b0;
            req_ready_r  <= 1'b1;
        end else begin
            resp_valid_r <= (state_r == DONE) && !(resp_valid_r && resp_ready);
            if (state_r == DONE) begin
                result_r <= (op_r == OP_MUL) ? p_r[31:0] : p_r[63:32];
            end else begin
                result_r <= result_r;
            end
            busy_r      <= (state_nx_s != IDLE);
            req_ready_r <= (state_nx_s == IDLE);
        end
    end

    assign resp_valid = resp_valid_r;
    assign result     = result_r;
    assign busy       = busy_r;
    assign req_ready  = req_ready_r;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq. A transaction-level model
// (64-bit arithmetic product plus latency from the operand signs) is checked
// against the DUT outputs on every falling clock edge; directed cases pin
// the model with hand-computed results and latencies.
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad = 0;

    mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full 64-bit product of the sign/zero-extended operands.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (o == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Reference latency: 33 cycles plus one per operand negation and two for result negation.
    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit na, nb;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        na = (o == 2'd1 || o == 2'd2) && a[31];
        nb = (o == 2'd1) && b[31];
        return 33 + int'(na) + int'(nb) + ((na != nb) ? 2 : 0);
    endfunction

    // Transaction model: idle / waiting for latency / responding.
    logic        m_busy = 1'b0;
    logic        m_rv = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_left <= 0;
            m_res  <= 32'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_left <= ref_lat(op, rs1, rs2);
                m_res  <= ref_res(op, rs1, rs2);
            end
        end else if (!m_rv) begin
            if (m_left == 1) m_rv <= 1'b1;
            m_left <= m_left - 1;
        end else if (resp_ready) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        check("resp_valid", resp_valid, m_rv);
        check("busy", busy, m_busy);
        check("req_ready", req_ready, !m_busy);
        if (m_rv) check("result", result, m_res);
        else if (!rst_n) check("result_in_reset", result, 32'd0);
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit poke,
                          output logic [31:0] got, output int lat);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0;
        while (!resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("resp_timeout", resp_valid, 1'b1);
        got = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = (poke && i == 3);
            check("hold_result", result, got);
            check("hold_valid", resp_valid, 1'b1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    logic [1:0]  d_op  [7] = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [31:0] d_a   [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    logic [31:0] d_b   [7] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd5};
    logic [31:0] d_res [7] = '{32'h2A, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h40000000, 32'hFFFFFFFF, 32'h0};
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    int          d_lat [7] = '{33, 33, 33, 35, 35, 36, 1};
`else
    int          d_lat [7] = '{33, 33, 33, 35, 35, 36, 33};
`endif

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] got;
        int lat;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_req_ready", req_ready, 1'b1);
        rst_n = 1'b1;

        // Directed cases with hand-computed results and latencies.
        for (int i = 0; i < 7; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], (i == 5) ? 10 : 0, (i == 5), got, lat);
            check($sformatf("dir%0d_result", i), got, d_res[i]);
            check($sformatf("dir%0d_latency", i), lat, d_lat[i]);
        end

        // Reset asserted in the middle of the iteration phase.
        @(negedge clk);
        op = 2'd0; rs1 = 32'd7; rs2 = 32'd9; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd0, 32'd3, 32'd5, 0, 1'b0, got, lat);
        check("after_rst_result", got, 32'h0000000F);
        check("after_rst_latency", lat, 33);

        // Randomized transactions checked by the model.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb, $urandom_range(0, 5), 1'($urandom_range(0, 1)), got, lat);
            check("rand_result", got, ref_res(ro, ra, rb));
            check("rand_latency", lat, ref_lat(ro, ra, rb));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
